// File: rtl/nibble_mult_if.sv
// nibble_mult_if: operand/product handshake bundle for nibble_mult_seq
interface nibble_mult_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [2*WIDTH-1:0] p;
  logic             busy;
  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, p, busy);
  modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, p, busy);
endinterface

// File: rtl/nibble_mult_seq.sv
// nibble_mult_seq: WIDTH x WIDTH multiplier time-sharing one 4x4 Wallace core
module wallace_mult_4bit (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] z
);
  logic [7:0] pp0, pp1, pp2, pp3, s1, c1, s2, c2;
  // two 3:2 carry-save levels, one final carry-propagate add
  always_comb begin
    pp0 = y[0] ? {4'b0, x}       : 8'd0;
    pp1 = y[1] ? {3'b0, x, 1'b0} : 8'd0;
    pp2 = y[2] ? {2'b0, x, 2'b0} : 8'd0;
    pp3 = y[3] ? {1'b0, x, 3'b0} : 8'd0;
    s1  = pp0 ^ pp1 ^ pp2;
    c1  = ((pp0 & pp1) | (pp0 & pp2) | (pp1 & pp2)) << 1;
    s2  = s1 ^ c1 ^ pp3;
    c2  = ((s1 & c1) | (s1 & pp3) | (c1 & pp3)) << 1;
    z   = s2 + c2;
  end
endmodule

module nibble_mult_seq #(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic rst,
  nibble_mult_if.slave bus
);
  localparam int N  = WIDTH / 4;
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [2*WIDTH-1:0] acc, acc_n, p_reg;
  logic [IW-1:0]      i, j;
  logic [3:0]         a_nib, b_nib;
  logic [7:0]         pp;
  logic               last;
  always_comb begin
    a_nib = a_reg[{i, 2'b00} +: 4];
    b_nib = b_reg[{j, 2'b00} +: 4];
    last  = (i == LAST) && (j == LAST);
    acc_n = acc + ((2*WIDTH)'(pp) << {({1'b0, i} + {1'b0, j}), 2'b00});
  end
  wallace_mult_4bit core (.x(a_nib), .y(b_nib), .z(pp));
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  always_comb begin
    state_n = state == IDLE ? (bus.in_valid  ? RUN  : IDLE) :
              state == RUN  ? (last          ? DONE : RUN)  :
                              (bus.out_ready ? IDLE : DONE);
  end
  always_comb begin
    bus.in_ready  = state == IDLE;
    bus.out_valid = state == DONE;
    bus.busy      = state != IDLE;
    bus.p         = p_reg;
  end
  // p is loaded with the final sum on the edge that enters DONE and held afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      p_reg <= '0;
      i     <= '0;
      j     <= '0;
    end else if (state == IDLE && bus.in_valid) begin
      a_reg <= bus.a;
      b_reg <= bus.b;
      acc   <= '0;
      i     <= '0;
      j     <= '0;
    end else if (state == RUN) begin
      acc   <= acc_n;
      j     <= j == LAST ? '0 : j + 1'b1;
      i     <= j == LAST ? i + 1'b1 : i;
      if (last) p_reg <= acc_n;
    end
  end
endmodule

// File: tb/tb_nibble_mult_seq.sv
// tb_nibble_mult_seq: directed and randomized checks of nibble_mult_seq at WIDTH=16 and WIDTH=8
module tb_nibble_mult_seq;
  logic clk = 0;
  logic rst;
  int errors = 0;
  int checks = 0;
  nibble_mult_if #(.WIDTH(16)) bus16();
  nibble_mult_if #(.WIDTH(8))  bus8();
  nibble_mult_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  nibble_mult_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, output int lat);
    bus16.a = a;
    bus16.b = b;
    bus16.in_valid = 1;
    tick();
    bus16.in_valid = 0;
    lat = 0;
    while (bus16.out_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1;
    bus16.in_valid = 0; bus16.a = 0; bus16.b = 0; bus16.out_ready = 0;
    bus8.in_valid = 0;  bus8.a = 0;  bus8.b = 0;  bus8.out_ready = 0;
    tick();
    tick();
    rst = 0;
    checks++; if (bus16.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus16.in_ready); end
    checks++; if (bus16.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus16.out_valid); end
    checks++; if (bus16.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus16.busy); end
    checks++; if (bus16.p !== 32'h0) begin errors++; $display("FAIL reset_p: got %h want 0", bus16.p); end
  endtask

  task automatic test_basic;
    int lat;
    bus16.out_ready = 1;
    issue(16'd3, 16'd5, lat);
    checks++; if (lat !== 16) begin errors++; $display("FAIL basic_latency: got %0d want 16", lat); end
    checks++; if (bus16.p !== 32'h0000000F) begin errors++; $display("FAIL basic_p: got %h want 0000000f", bus16.p); end
    checks++; if (bus16.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", bus16.busy); end
    checks++; if (bus16.in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_done: got %b want 0", bus16.in_ready); end
    tick();
    checks++; if (bus16.out_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b want 0", bus16.out_valid); end
    checks++; if (bus16.in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready_back: got %b want 1", bus16.in_ready); end
    checks++; if (bus16.p !== 32'h0000000F) begin errors++; $display("FAIL basic_p_retained: got %h want 0000000f", bus16.p); end
  endtask

  task automatic test_extremes;
    int lat;
    bus16.out_ready = 1;
    issue(16'hFFFF, 16'hFFFF, lat);
    checks++; if (lat !== 16) begin errors++; $display("FAIL max_latency: got %0d want 16", lat); end
    checks++; if (bus16.p !== 32'hFFFE0001) begin errors++; $display("FAIL max_p: got %h want fffe0001", bus16.p); end
    tick();
    issue(16'h1234, 16'h0000, lat);
    checks++; if (lat !== 16) begin errors++; $display("FAIL zero_latency: got %0d want 16", lat); end
    checks++; if (bus16.p !== 32'h0) begin errors++; $display("FAIL zero_p: got %h want 0", bus16.p); end
    tick();
  endtask

  task automatic test_stall;
    int lat;
    bus16.out_ready = 0;
    issue(16'hABCD, 16'h1357, lat);
    checks++; if (lat !== 16) begin errors++; $display("FAIL stall_latency: got %0d want 16", lat); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (bus16.out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid[%0d]: got %b want 1", k, bus16.out_valid); end
      checks++; if (bus16.p !== 32'h0CFA99AB) begin errors++; $display("FAIL stall_p[%0d]: got %h want 0cfa99ab", k, bus16.p); end
      checks++; if (bus16.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b want 0", k, bus16.in_ready); end
    end
    bus16.out_ready = 1;
    tick();
    checks++; if (bus16.out_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", bus16.out_valid); end
    checks++; if (bus16.p !== 32'h0CFA99AB) begin errors++; $display("FAIL stall_p_after: got %h want 0cfa99ab", bus16.p); end
  endtask

  task automatic test_reset_mid;
    int lat;
    bit seen = 0;
    bus16.out_ready = 1;
    bus16.a = 16'd7; bus16.b = 16'd7; bus16.in_valid = 1;
    tick();
    bus16.in_valid = 0;
    repeat (6) tick();
    rst = 1;
    tick();
    rst = 0;
    checks++; if (bus16.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", bus16.in_ready); end
    checks++; if (bus16.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", bus16.out_valid); end
    checks++; if (bus16.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus16.busy); end
    checks++; if (bus16.p !== 32'h0) begin errors++; $display("FAIL midrst_p: got %h want 0", bus16.p); end
    for (int k = 0; k < 20; k++) begin
      if (bus16.out_valid === 1'b1) seen = 1;
      tick();
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_output: got %b want 0", seen); end
    issue(16'd2, 16'd9, lat);
    checks++; if (lat !== 16) begin errors++; $display("FAIL midrst_new_latency: got %0d want 16", lat); end
    checks++; if (bus16.p !== 32'd18) begin errors++; $display("FAIL midrst_new_p: got %h want 00000012", bus16.p); end
    tick();
  endtask

  task automatic test_ignore;
    int lat = 0;
    bus16.out_ready = 1;
    bus16.a = 16'h0011; bus16.b = 16'h0022; bus16.in_valid = 1;
    tick();
    while (bus16.out_valid !== 1'b1 && lat < 100) begin
      bus16.a = 16'(lat * 37 + 5);
      bus16.b = 16'(16'hF0F0 ^ lat);
      tick();
      lat++;
    end
    bus16.in_valid = 0;
    checks++; if (lat !== 16) begin errors++; $display("FAIL ignore_latency: got %0d want 16", lat); end
    checks++; if (bus16.p !== 32'h00000242) begin errors++; $display("FAIL ignore_p: got %h want 00000242", bus16.p); end
    tick();
    checks++; if (bus16.in_ready !== 1'b1) begin errors++; $display("FAIL ignore_in_ready: got %b want 1", bus16.in_ready); end
  endtask

  task automatic test_width8;
    int lat = 0;
    bus8.out_ready = 1;
    bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.in_valid = 1;
    tick();
    bus8.in_valid = 0;
    while (bus8.out_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL w8_latency: got %0d want 4", lat); end
    checks++; if (bus8.p !== 16'hFE01) begin errors++; $display("FAIL w8_p: got %h want fe01", bus8.p); end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [31:0] q16[$];
    logic [15:0] q8[$];
    logic [31:0] e16;
    logic [15:0] e8;
    int acc16 = 0, acc8 = 0, out16 = 0, out8 = 0, cycles = 0;
    while ((acc16 < 1000 || acc8 < 1000 || q16.size() != 0 || q8.size() != 0) && cycles < 40000) begin
      bus16.in_valid  = acc16 < 1000 && $urandom_range(3) != 0;
      bus16.a         = 16'($urandom);
      bus16.b         = 16'($urandom);
      bus16.out_ready = $urandom_range(3) != 0;
      bus8.in_valid   = acc8 < 1000 && $urandom_range(3) != 0;
      bus8.a          = 8'($urandom);
      bus8.b          = 8'($urandom);
      bus8.out_ready  = $urandom_range(3) != 0;
      if (bus16.in_valid && bus16.in_ready) begin q16.push_back(32'(bus16.a) * 32'(bus16.b)); acc16++; end
      if (bus8.in_valid && bus8.in_ready) begin q8.push_back(16'(bus8.a) * 16'(bus8.b)); acc8++; end
      if (bus16.out_valid && bus16.out_ready) begin
        e16 = q16.size() != 0 ? q16.pop_front() : 'x;
        out16++;
        checks++; if (bus16.p !== e16) begin errors++; $display("FAIL rand16_p[%0d]: got %h want %h", out16, bus16.p, e16); end
      end
      if (bus8.out_valid && bus8.out_ready) begin
        e8 = q8.size() != 0 ? q8.pop_front() : 'x;
        out8++;
        checks++; if (bus8.p !== e8) begin errors++; $display("FAIL rand8_p[%0d]: got %h want %h", out8, bus8.p, e8); end
      end
      tick();
      cycles++;
    end
    bus16.in_valid = 0;
    bus8.in_valid = 0;
    checks++; if (cycles >= 40000) begin errors++; $display("FAIL rand_timeout: got %0d cycles want < 40000", cycles); end
    checks++; if (acc16 !== 1000) begin errors++; $display("FAIL rand16_accepts: got %0d want 1000", acc16); end
    checks++; if (out16 !== acc16) begin errors++; $display("FAIL rand16_outputs: got %0d want %0d", out16, acc16); end
    checks++; if (acc8 !== 1000) begin errors++; $display("FAIL rand8_accepts: got %0d want 1000", acc8); end
    checks++; if (out8 !== acc8) begin errors++; $display("FAIL rand8_outputs: got %0d want %0d", out8, acc8); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_stall();
    test_reset_mid();
    test_ignore();
    test_width8();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
